// File: rtl/pcie_link_trainer_pkg.sv
// Shared definitions for the PCIe link trainer: LTSSM state encoding and
// 10b symbol constants used by the per-lane training-sequence detectors.
package pcie_link_trainer_pkg;

    typedef enum logic [2:0] {
        DISABLED      = 3'd0,
        DETECT_QUIET  = 3'd1,
        DETECT_ACTIVE = 3'd2,
        POLL_ACTIVE   = 3'd3,
        POLL_CONFIG   = 3'd4,
        LINK_UP       = 3'd5
    } ltState_e;

    localparam int NumLanes = 16;

    localparam logic [9:0] COM_RDN    = 10'h17C;
    localparam logic [9:0] COM_RDP    = 10'h283;
    localparam logic [9:0] TS_ID_NORM = 10'h155;
    localparam logic [9:0] TS_ID_INV  = 10'h2AA;

    // COM may arrive with either running disparity.
    function automatic logic isCom(input logic [9:0] sym);
        return (sym == COM_RDN) || (sym == COM_RDP);
    endfunction

endpackage

// File: rtl/pcie_ts_lane_det.sv
// Per-lane training-sequence detector: aligns on COM, checks the ident symbol
// and counts consecutive valid TS of one receive polarity.
module pcie_ts_lane_det
    import pcie_link_trainer_pkg::*;
#(
    parameter int PollTsCount = 8
)(
    input  logic       Clk,
    input  logic       notReset,
    input  logic       Clear,
    input  logic [9:0] Symbol,
    output logic       TsDone,
    output logic       Polarity
);

    localparam int              CntW   = $clog2(PollTsCount + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(PollTsCount);

    logic [2:0]      posReg;
    logic [CntW-1:0] countReg;
    logic            polReg;
    logic            identValid;
    logic            identPol;

    always_comb begin
        identValid = (Symbol == TS_ID_NORM) || (Symbol == TS_ID_INV);
        identPol   = (Symbol == TS_ID_INV);
    end

    // posReg == 0 means not yet aligned; a COM always realigns, even at the ident slot.
    always_ff @(posedge Clk) begin
        if (!notReset || Clear) begin
            posReg   <= 3'd0;
            countReg <= '0;
            polReg   <= 1'b0;
        end else if (isCom(Symbol)) begin
            posReg <= 3'd1;
        end else if (posReg != 3'd0) begin
            if (posReg != 3'd7) begin
                posReg <= posReg + 3'd1;
            end
            if (posReg == 3'd6) begin
                if (!identValid) begin
                    countReg <= '0;
                end else if (identPol != polReg) begin
                    polReg   <= identPol;
                    countReg <= CntW'(1);
                end else if (countReg != CntMax) begin
                    countReg <= countReg + CntW'(1);
                end
            end
        end
    end

    assign TsDone   = (countReg == CntMax);
    assign Polarity = polReg;

endmodule

// File: rtl/pcie_link_trainer.sv
// Simplified PCIe LTSSM: receiver detect, polling with per-lane TS counting
// and polarity capture, then link-up until the far end goes electrically idle.
module pcie_link_trainer
    import pcie_link_trainer_pkg::*;
#(
    parameter int LinkWidth     = 16,
    parameter int QuietCycles   = 12,
    parameter int PollTsCount   = 8,
    parameter int TimeoutCycles = 1024
)(
    input  logic         Clk,
    input  logic         notReset,
    input  logic         Enable,
    input  logic [159:0] LinkIn,
    input  logic [15:0]  ElecIdleIn,
    input  logic [15:0]  RxPresent,
    output logic [15:0]  ElecIdleOut,
    output logic [15:0]  InvertIn,
    output logic         ReverseIn,
    output logic [15:0]  ActiveLanes,
    output logic         LinkUp,
    output logic [2:0]   LtState,
    output logic         Timeout
);

    localparam int          TimerMax = (TimeoutCycles > QuietCycles) ? TimeoutCycles : QuietCycles;
    localparam int          TimerW   = $clog2(TimerMax + 1);
    localparam logic [16:0] MaskWide = (17'd1 << LinkWidth) - 17'd1;
    localparam logic [15:0] LaneMask = MaskWide[15:0];

    ltState_e          stateReg;
    logic [TimerW-1:0] timerReg;
    logic [15:0]       laneDone;
    logic [15:0]       lanePol;
    logic [15:0]       detectMask;
    logic              clearDet;
    logic              pollExit;
    logic              idleAll;

    // Detectors only run while polling; they hold their last values through POLL_CONFIG.
    assign clearDet = (stateReg != POLL_ACTIVE);

    generate
        for (genvar gi = 0; gi < NumLanes; gi++) begin : gLane
            pcie_ts_lane_det #(
                .PollTsCount(PollTsCount)
            ) uDet (
                .Clk     (Clk),
                .notReset(notReset),
                .Clear   (clearDet),
                .Symbol  (LinkIn[10*gi +: 10]),
                .TsDone  (laneDone[gi]),
                .Polarity(lanePol[gi])
            );
        end
    endgenerate

    always_comb begin
        detectMask = RxPresent & LaneMask;
        pollExit   = ((laneDone & ActiveLanes) == ActiveLanes);
        idleAll    = ((ElecIdleIn & ActiveLanes) == ActiveLanes);
    end

    assign LtState = stateReg;

    always_ff @(posedge Clk) begin
        if (!notReset) begin
            stateReg    <= DISABLED;
            timerReg    <= '0;
            ElecIdleOut <= '1;
            InvertIn    <= '0;
            ReverseIn   <= 1'b0;
            ActiveLanes <= '0;
            LinkUp      <= 1'b0;
            Timeout     <= 1'b0;
        end else begin
            Timeout <= 1'b0;
            if (!Enable) begin
                stateReg    <= DISABLED;
                timerReg    <= '0;
                ElecIdleOut <= '1;
                LinkUp      <= 1'b0;
            end else begin
                unique case (stateReg)
                    DISABLED: begin
                        stateReg    <= DETECT_QUIET;
                        timerReg    <= '0;
                        ElecIdleOut <= '1;
                        InvertIn    <= '0;
                        ReverseIn   <= 1'b0;
                        LinkUp      <= 1'b0;
                    end
                    DETECT_QUIET: begin
                        if (timerReg == TimerW'(QuietCycles - 1)) begin
                            stateReg <= DETECT_ACTIVE;
                        end else begin
                            timerReg <= timerReg + TimerW'(1);
                        end
                    end
                    DETECT_ACTIVE: begin
                        ActiveLanes <= detectMask;
                        ReverseIn   <= ~RxPresent[0] & RxPresent[LinkWidth-1];
                        timerReg    <= '0;
                        if (detectMask == '0) begin
                            stateReg <= DETECT_QUIET;
                        end else begin
                            stateReg    <= POLL_ACTIVE;
                            ElecIdleOut <= ~detectMask;
                        end
                    end
                    POLL_ACTIVE: begin
                        // A lane set completing on the last timer cycle still trains.
                        if (pollExit) begin
                            stateReg <= POLL_CONFIG;
                        end else if (timerReg == TimerW'(TimeoutCycles - 1)) begin
                            stateReg    <= DETECT_QUIET;
                            timerReg    <= '0;
                            Timeout     <= 1'b1;
                            ElecIdleOut <= '1;
                            InvertIn    <= '0;
                            ReverseIn   <= 1'b0;
                        end else begin
                            timerReg <= timerReg + TimerW'(1);
                        end
                    end
                    POLL_CONFIG: begin
                        InvertIn    <= lanePol & ActiveLanes;
                        ElecIdleOut <= ~ActiveLanes;
                        LinkUp      <= 1'b1;
                        stateReg    <= LINK_UP;
                    end
                    LINK_UP: begin
                        if (idleAll) begin
                            stateReg    <= DETECT_QUIET;
                            timerReg    <= '0;
                            ElecIdleOut <= '1;
                            InvertIn    <= '0;
                            ReverseIn   <= 1'b0;
                            LinkUp      <= 1'b0;
                        end
                    end
                    default: begin
                        stateReg <= DISABLED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcie_link_trainer.sv
// Directed bench for pcie_link_trainer: one x4 and one x16 instance share stimulus;
// each scenario checks the instance whose width it targets.
module tb_pcie_link_trainer;

    logic         clk = 1'b0;
    logic         notReset;
    logic         enable;
    logic [159:0] linkIn;
    logic [15:0]  elecIdleIn;
    logic [15:0]  rxPresent;

    logic [15:0] elecIdleOutA, invertInA, activeLanesA;
    logic        reverseInA, linkUpA, timeoutA;
    logic [2:0]  ltStateA;
    logic [15:0] elecIdleOutB, invertInB, activeLanesB;
    logic        reverseInB, linkUpB, timeoutB;
    logic [2:0]  ltStateB;

    int totalCount = 0;
    int badCount   = 0;

    always #5 clk = ~clk;

    pcie_link_trainer #(.LinkWidth(4)) uDutA (
        .Clk(clk), .notReset(notReset), .Enable(enable), .LinkIn(linkIn),
        .ElecIdleIn(elecIdleIn), .RxPresent(rxPresent),
        .ElecIdleOut(elecIdleOutA), .InvertIn(invertInA), .ReverseIn(reverseInA),
        .ActiveLanes(activeLanesA), .LinkUp(linkUpA), .LtState(ltStateA), .Timeout(timeoutA)
    );

    pcie_link_trainer #(.LinkWidth(16)) uDutB (
        .Clk(clk), .notReset(notReset), .Enable(enable), .LinkIn(linkIn),
        .ElecIdleIn(elecIdleIn), .RxPresent(rxPresent),
        .ElecIdleOut(elecIdleOutB), .InvertIn(invertInB), .ReverseIn(reverseInB),
        .ActiveLanes(activeLanesB), .LinkUp(linkUpB), .LtState(ltStateB), .Timeout(timeoutB)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("check %s: got=%0h", tag, got);
        end
    endtask

    // Drive symbol k (0..7) of an 8-symbol TS on every lane in send.
    task automatic setSymbols(input int k, input logic [15:0] send, input logic [15:0] inv,
                              input logic [15:0] bad);
        logic [9:0] s;
        for (int ln = 0; ln < 16; ln++) begin
            if (!send[ln])  s = 10'h000;
            else if (k == 0) s = ln[0] ? 10'h283 : 10'h17C;
            else if (k == 6) s = bad[ln] ? 10'h0AA : (inv[ln] ? 10'h2AA : 10'h155);
            else             s = 10'h0F0;
            linkIn[10*ln +: 10] = s;
        end
    endtask

    task automatic sendTs(input logic [15:0] send, input logic [15:0] inv,
                          input logic [15:0] bad, input int n);
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                setSymbols(k, send, inv, bad);
            end
        end
    endtask

    task automatic waitState(input bit wide, input logic [2:0] target, input int budget,
                             input string tag);
        logic [2:0] st;
        int n = 0;
        do begin
            @(negedge clk);
            st = wide ? ltStateB : ltStateA;
            n++;
        end while (st != target && n < budget);
        checkVal(tag, {29'd0, st}, {29'd0, target});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [2:0] st;

        notReset   = 1'b0;
        enable     = 1'b0;
        linkIn     = '0;
        elecIdleIn = '0;
        rxPresent  = '0;
        repeat (3) @(negedge clk);

        // Reset values
        checkVal("rst_state",  ltStateA,     3'd0);
        checkVal("rst_eidle",  elecIdleOutA, 16'hFFFF);
        checkVal("rst_invert", invertInA,    16'h0000);
        checkVal("rst_rev",    reverseInA,   1'b0);
        checkVal("rst_active", activeLanesA, 16'h0000);
        checkVal("rst_linkup", linkUpA,      1'b0);
        checkVal("rst_tmo",    timeoutA,     1'b0);

        // No receivers: quiet lasts exactly 12 cycles, detect bounces back to quiet
        notReset = 1'b1;
        enable   = 1'b1;
        waitState(1'b0, 3'd1, 5, "dq_enter");
        cnt = 1;
        st  = 3'd1;
        while (cnt < 100) begin
            @(negedge clk);
            st = ltStateA;
            if (st != 3'd1) break;
            cnt++;
        end
        checkVal("dq_len", cnt, 12);
        checkVal("da_after_dq", st, 3'd2);
        @(negedge clk);
        checkVal("dq_again", ltStateA, 3'd1);
        checkVal("norx_active", activeLanesA, 16'h0000);
        checkVal("norx_linkup", linkUpA, 1'b0);

        // x4 training with an invalid ident on lane 0 part way through
        enable = 1'b0;
        @(negedge clk);
        checkVal("dis_force", ltStateA, 3'd0);
        enable    = 1'b1;
        rxPresent = 16'h000F;
        waitState(1'b0, 3'd3, 40, "x4_poll");
        checkVal("x4_poll_eidle", elecIdleOutA, 16'hFFF0);
        sendTs(16'h000F, 16'h0000, 16'h0000, 4);
        sendTs(16'h000F, 16'h0000, 16'h0001, 1);
        sendTs(16'h000F, 16'h0000, 16'h0000, 7);
        @(negedge clk);
        checkVal("x4_bad_holds", ltStateA, 3'd3);
        sendTs(16'h000F, 16'h0000, 16'h0000, 1);
        waitState(1'b0, 3'd5, 10, "x4_linkup_state");
        checkVal("x4_linkup",  linkUpA,      1'b1);
        checkVal("x4_active",  activeLanesA, 16'h000F);
        checkVal("x4_invert",  invertInA,    16'h0000);
        checkVal("x4_eidle",   elecIdleOutA, 16'hFFF0);
        checkVal("x4_rev",     reverseInA,   1'b0);

        // Far-end idle: partial set keeps link, full active set drops to quiet
        elecIdleIn = 16'h0007;
        @(negedge clk);
        checkVal("partial_idle", ltStateA, 3'd5);
        elecIdleIn = 16'h000F;
        @(negedge clk);
        checkVal("idle_to_dq",   ltStateA,     3'd1);
        checkVal("idle_linkup",  linkUpA,      1'b0);
        checkVal("idle_eidle",   elecIdleOutA, 16'hFFFF);
        elecIdleIn = 16'h0000;

        // Lane 2 flips to inverted after 3 TS; lanes 4-7 present but beyond width
        rxPresent = 16'h00FF;
        waitState(1'b0, 3'd3, 40, "inv_poll");
        checkVal("mask_active", activeLanesA, 16'h000F);
        sendTs(16'h00FF, 16'h0020, 16'h0000, 3);
        sendTs(16'h00FF, 16'h0024, 16'h0000, 7);
        @(negedge clk);
        checkVal("pol_restart", ltStateA, 3'd3);
        sendTs(16'h00FF, 16'h0024, 16'h0000, 1);
        waitState(1'b0, 3'd5, 10, "inv_linkup_state");
        checkVal("inv_invert", invertInA, 16'h0004);

        // x16 with only lane 15 present: lane reversal
        enable = 1'b0;
        @(negedge clk);
        enable    = 1'b1;
        rxPresent = 16'h8000;
        waitState(1'b1, 3'd3, 40, "rev_poll");
        checkVal("rev_rev",    reverseInB,   1'b1);
        checkVal("rev_active", activeLanesB, 16'h8000);
        checkVal("rev_eidle",  elecIdleOutB, 16'h7FFF);
        sendTs(16'h8000, 16'h0000, 16'h0000, 8);
        waitState(1'b1, 3'd5, 10, "rev_linkup_state");
        checkVal("rev_linkup", linkUpB, 1'b1);

        // Lane 1 silent: poll times out after 1024 cycles
        enable = 1'b0;
        @(negedge clk);
        enable    = 1'b1;
        rxPresent = 16'h000F;
        waitState(1'b0, 3'd3, 40, "tmo_poll");
        cnt = 1;
        st  = 3'd3;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            setSymbols(c % 8, 16'h000D, 16'h0000, 16'h0000);
            st = ltStateA;
            if (st != 3'd3) break;
            cnt++;
        end
        checkVal("tmo_len",    cnt,      1024);
        checkVal("tmo_state",  st,       3'd1);
        checkVal("tmo_pulse",  timeoutA, 1'b1);
        checkVal("tmo_linkup", linkUpA,  1'b0);
        @(negedge clk);
        checkVal("tmo_pulse_end", timeoutA, 1'b0);

        // Reset in the middle of polling
        waitState(1'b0, 3'd3, 40, "rst_poll");
        sendTs(16'h000F, 16'h0000, 16'h0000, 2);
        @(negedge clk);
        notReset = 1'b0;
        @(negedge clk);
        checkVal("mid_rst_state",  ltStateA,     3'd0);
        checkVal("mid_rst_eidle",  elecIdleOutA, 16'hFFFF);
        checkVal("mid_rst_active", activeLanesA, 16'h0000);
        checkVal("mid_rst_activeB", activeLanesB, 16'h0000);
        checkVal("mid_rst_linkup", linkUpA,      1'b0);
        checkVal("mid_rst_invert", invertInA,    16'h0000);
        checkVal("mid_rst_tmo",    timeoutA,     1'b0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
